// File: rtl/aip_int_handler.sv
// Host-side AIP interrupt servicer: programs mask, reads status on intReq low, pulses irqEvent, writes clears back.
// Latency: intReq->busRd 1 cycle, read ack->irqValid 1 cycle; requests held until busAck or TIMEOUT_CYC expiry.
module aip_int_handler #(
    parameter int TIMEOUT_CYC = 255,
    parameter int HOLDOFF_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cfgMask,
    input  logic        cfgLoad,
    input  logic        intReq,
    output logic        busRd,
    output logic        busWr,
    output logic [31:0] busWrData,
    input  logic [31:0] busRdData,
    input  logic        busAck,
    output logic [7:0]  irqEvent,
    output logic        irqValid,
    output logic [7:0]  statusFlags,
    output logic        busy,
    output logic        spurious,
    output logic        errTimeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_WR,
        S_WAIT_INT,
        S_RD_REQ,
        S_DISPATCH,
        S_CLR_WR,
        S_HOLD
    } state_t;

    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYC - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  mask_q, mask_d;
    logic [7:0]  pend_q, pend_d;
    logic        cfg_pend_q, cfg_pend_d;
    logic [7:0]  cfg_mask_q, cfg_mask_d;
    logic [7:0]  status_q, status_d;
    logic        err_q, err_d;
    logic        tmo_hit;
    logic        unused_rd_hi;

    // Top byte of the status word carries nothing we consume.
    assign unused_rd_hi = ^busRdData[31:24];

    assign tmo_hit     = (cnt_q == TMO_LAST);
    assign busy        = (state_q != S_WAIT_INT);
    assign statusFlags = status_q;
    assign errTimeout  = err_q;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        pend_d     = pend_q;
        cfg_pend_d = cfg_pend_q;
        cfg_mask_d = cfg_mask_q;
        status_d   = status_q;
        err_d      = err_q;
        busRd      = 1'b0;
        busWr      = 1'b0;
        busWrData  = 32'h0;
        irqEvent   = 8'h00;
        irqValid   = 1'b0;
        spurious   = 1'b0;

        // A cfgLoad in any state is remembered; the last one wins.
        if (cfgLoad) begin
            cfg_pend_d = 1'b1;
            cfg_mask_d = cfgMask;
            err_d      = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                state_d = S_CFG_WR;
            end
            S_CFG_WR: begin
                busWr     = 1'b1;
                busWrData = {8'h00, mask_q, 16'h0000};
                if (busAck) begin
                    state_d = S_HOLD;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_WAIT_INT: begin
                if (cfgLoad) begin
                    mask_d     = cfgMask;
                    cfg_pend_d = 1'b0;
                    state_d    = S_CFG_WR;
                end else if (cfg_pend_q) begin
                    mask_d     = cfg_mask_q;
                    cfg_pend_d = 1'b0;
                    state_d    = S_CFG_WR;
                end else if (!intReq) begin
                    state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                busRd = 1'b1;
                if (busAck) begin
                    pend_d   = busRdData[7:0] & busRdData[23:16];
                    status_d = busRdData[15:8];
                    state_d  = S_DISPATCH;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_DISPATCH: begin
                if (pend_q != 8'h00) begin
                    irqEvent = pend_q;
                    irqValid = 1'b1;
                    state_d  = S_CLR_WR;
                end else begin
                    spurious = 1'b1;
                    state_d  = S_HOLD;
                end
            end
            S_CLR_WR: begin
                busWr     = 1'b1;
                busWrData = {8'h00, mask_q, 8'h00, pend_q};
                if (busAck) begin
                    state_d = S_HOLD;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // Leaving HOLD is the WAIT_INT entry point, so a deferred mask goes straight out.
                if (cnt_q == HOLD_LAST) begin
                    if (cfgLoad) begin
                        mask_d     = cfgMask;
                        cfg_pend_d = 1'b0;
                        state_d    = S_CFG_WR;
                    end else if (cfg_pend_q) begin
                        mask_d     = cfg_mask_q;
                        cfg_pend_d = 1'b0;
                        state_d    = S_CFG_WR;
                    end else begin
                        state_d = S_WAIT_INT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cnt_d = (state_d != state_q) ? 8'h00 : cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'h00;
            mask_q     <= 8'h00;
            pend_q     <= 8'h00;
            cfg_pend_q <= 1'b0;
            cfg_mask_q <= 8'h00;
            status_q   <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            cfg_pend_q <= cfg_pend_d;
            cfg_mask_q <= cfg_mask_d;
            status_q   <= status_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_aip_int_handler.sv
// Bench for aip_int_handler: plays the AIP status block and checks against an expected-value model.
module tb_aip_int_handler;

    localparam int TMO = 255;

    logic        clk;
    logic        rst;
    logic [7:0]  cfgMask;
    logic        cfgLoad;
    logic        intReq;
    logic        busRd;
    logic        busWr;
    logic [31:0] busWrData;
    logic [31:0] busRdData;
    logic        busAck;
    logic [7:0]  irqEvent;
    logic        irqValid;
    logic [7:0]  statusFlags;
    logic        busy;
    logic        spurious;
    logic        errTimeout;

    int checks;
    int failures;
    logic [7:0] cur_mask;

    aip_int_handler #(.TIMEOUT_CYC(TMO), .HOLDOFF_CYC(2)) dut (
        .clk(clk), .rst(rst), .cfgMask(cfgMask), .cfgLoad(cfgLoad), .intReq(intReq),
        .busRd(busRd), .busWr(busWr), .busWrData(busWrData), .busRdData(busRdData),
        .busAck(busAck), .irqEvent(irqEvent), .irqValid(irqValid), .statusFlags(statusFlags),
        .busy(busy), .spurious(spurious), .errTimeout(errTimeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus protocol invariants watched on every cycle.
    logic        prev_wr;
    logic [31:0] prev_data;
    initial begin
        prev_wr = 1'b0;
        prev_data = 32'h0;
    end
    always @(negedge clk) begin
        checks++;
        if (busRd && busWr) begin
            failures++;
            $display("FAIL rd_wr_exclusive: busRd=%b busWr=%b, required not both high", busRd, busWr);
        end
        if (busWr && prev_wr) begin
            checks++;
            if (busWrData !== prev_data) begin
                failures++;
                $display("FAIL wrdata_stable: got %h, required %h", busWrData, prev_data);
            end
        end
        prev_wr = busWr;
        prev_data = busWrData;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_wr(output bit ok, output logic [31:0] d);
        ok = 1'b0;
        d = 32'h0;
        for (int i = 0; i < 40; i++) begin
            if (busWr) begin
                ok = 1'b1;
                d = busWrData;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busRd) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_ack(input logic [31:0] rd);
        busAck = 1'b1;
        busRdData = rd;
        @(negedge clk);
        busAck = 1'b0;
        busRdData = $urandom;
    endtask

    task automatic cfg_write(input logic [7:0] m, output bit ok, output logic [31:0] d);
        bit r;
        cfgMask = m;
        cfgLoad = 1'b1;
        @(negedge clk);
        cfgLoad = 1'b0;
        wait_wr(ok, d);
        if (ok) do_ack(32'h0);
        wait_ready(r);
        ok = ok & r;
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busRd, busWr, irqValid, spurious, errTimeout} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: rd/wr/vld/spur/err=%b, required 00000",
                     {busRd, busWr, irqValid, spurious, errTimeout});
        end
        checks++;
        if (busWrData !== 32'h0 || irqEvent !== 8'h00 || statusFlags !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: wrdata=%h ev=%h st=%h, required zeros", busWrData, irqEvent, statusFlags);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy: got %b, required 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busWr !== 1'b1 || busWrData !== 32'h0) begin
            failures++;
            $display("FAIL powerup_cfg: busWr=%b data=%h, required 1 00000000", busWr, busWrData);
        end
        do_ack(32'h0);
        checks++;
        if (busy !== 1'b1 || busWr !== 1'b0) begin
            failures++;
            $display("FAIL hold1: busy=%b busWr=%b, required 1 0", busy, busWr);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL hold2: busy=%b, required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_exit: busy=%b, required 0", busy);
        end
        cur_mask = 8'h00;
    endtask

    task automatic test_basic();
        bit ok;
        logic [31:0] d;
        cfgMask = 8'h03;
        cfgLoad = 1'b1;
        @(negedge clk);
        cfgLoad = 1'b0;
        checks++;
        if (busWr !== 1'b1 || busWrData !== 32'h0003_0000) begin
            failures++;
            $display("FAIL basic_cfg: busWr=%b data=%h, required 1 00030000", busWr, busWrData);
        end
        do_ack(32'h0);
        wait_ready(ok);
        cur_mask = 8'h03;
        intReq = 1'b0;
        @(negedge clk);
        checks++;
        if (busRd !== 1'b1) begin
            failures++;
            $display("FAIL basic_rd_latency: busRd=%b, required 1", busRd);
        end
        intReq = 1'b1;
        do_ack(32'h0003_0101);
        checks++;
        if (irqValid !== 1'b1 || irqEvent !== 8'h01 || statusFlags !== 8'h01) begin
            failures++;
            $display("FAIL basic_event: vld=%b ev=%h st=%h, required 1 01 01", irqValid, irqEvent, statusFlags);
        end
        @(negedge clk);
        checks++;
        if (irqValid !== 1'b0 || busWr !== 1'b1 || busWrData !== 32'h0003_0001) begin
            failures++;
            $display("FAIL basic_clear: vld=%b wr=%b data=%h, required 0 1 00030001", irqValid, busWr, busWrData);
        end
        do_ack(32'h0);
        wait_ready(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_ready: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_partial();
        bit ok;
        logic [31:0] d;
        cfg_write(8'h01, ok, d);
        cur_mask = 8'h01;
        checks++;
        if (!ok || d !== 32'h0001_0000) begin
            failures++;
            $display("FAIL partial_cfg: ok=%b data=%h, required 1 00010000", ok, d);
        end
        intReq = 1'b0;
        wait_rd(ok);
        intReq = 1'b1;
        do_ack(32'h0001_0003);
        checks++;
        if (irqValid !== 1'b1 || irqEvent !== 8'h01) begin
            failures++;
            $display("FAIL partial_event: vld=%b ev=%h, required 1 01", irqValid, irqEvent);
        end
        wait_wr(ok, d);
        checks++;
        if (!ok || d !== 32'h0001_0001) begin
            failures++;
            $display("FAIL partial_clear: ok=%b data=%h, required 1 00010001", ok, d);
        end
        if (ok) do_ack(32'h0);
        wait_ready(ok);
    endtask

    task automatic test_spurious();
        bit ok;
        bit saw_wr;
        bit saw_spur;
        logic [31:0] d;
        cfg_write(8'h00, ok, d);
        cur_mask = 8'h00;
        checks++;
        if (!ok || d !== 32'h0000_0000) begin
            failures++;
            $display("FAIL spur_cfg: ok=%b data=%h, required 1 00000000", ok, d);
        end
        intReq = 1'b0;
        wait_rd(ok);
        intReq = 1'b1;
        do_ack(32'h0000_0001);
        checks++;
        if (spurious !== 1'b1 || irqValid !== 1'b0) begin
            failures++;
            $display("FAIL spur_pulse: spur=%b vld=%b, required 1 0", spurious, irqValid);
        end
        saw_wr = 1'b0;
        saw_spur = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            saw_wr |= busWr;
            saw_spur |= spurious;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (saw_wr || saw_spur || !ok) begin
            failures++;
            $display("FAIL spur_after: wr=%b spur_again=%b idle=%b, required 0 0 1", saw_wr, saw_spur, ok);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit saw_v;
        int n;
        logic [31:0] d;
        cfg_write(8'h03, ok, d);
        cur_mask = 8'h03;
        intReq = 1'b0;
        wait_rd(ok);
        intReq = 1'b1;
        n = 0;
        saw_v = 1'b0;
        while (busRd && n < 400) begin
            n++;
            @(negedge clk);
            saw_v |= irqValid;
        end
        checks++;
        if (n != TMO) begin
            failures++;
            $display("FAIL tmo_len: busRd held %0d cycles, required %0d", n, TMO);
        end
        for (int i = 0; i < 10 && busy; i++) begin
            @(negedge clk);
            saw_v |= irqValid;
        end
        checks++;
        if (errTimeout !== 1'b1 || saw_v || busy !== 1'b0) begin
            failures++;
            $display("FAIL tmo_flag: err=%b irqValid_seen=%b busy=%b, required 1 0 0", errTimeout, saw_v, busy);
        end
        cfgMask = 8'h03;
        cfgLoad = 1'b1;
        @(negedge clk);
        cfgLoad = 1'b0;
        checks++;
        if (errTimeout !== 1'b0 || busWrData !== 32'h0003_0000) begin
            failures++;
            $display("FAIL tmo_clear: err=%b data=%h, required 0 00030000", errTimeout, busWrData);
        end
        do_ack(32'h0);
        wait_ready(ok);
    endtask

    task automatic test_timeout_edge();
        bit ok;
        logic [31:0] d;
        intReq = 1'b0;
        wait_rd(ok);
        intReq = 1'b1;
        repeat (TMO - 1) @(negedge clk);
        checks++;
        if (busRd !== 1'b1) begin
            failures++;
            $display("FAIL edge_rd_held: busRd=%b on cycle %0d, required 1", busRd, TMO);
        end
        do_ack(32'h0003_0002);
        checks++;
        if (irqValid !== 1'b1 || irqEvent !== 8'h02 || errTimeout !== 1'b0) begin
            failures++;
            $display("FAIL edge_ack: vld=%b ev=%h err=%b, required 1 02 0", irqValid, irqEvent, errTimeout);
        end
        wait_wr(ok, d);
        checks++;
        if (!ok || d !== 32'h0003_0002) begin
            failures++;
            $display("FAIL edge_clear: ok=%b data=%h, required 1 00030002", ok, d);
        end
        if (ok) do_ack(32'h0);
        wait_ready(ok);
    endtask

    task automatic test_cfg_during_clr();
        bit ok;
        bit went_idle;
        logic [31:0] d;
        intReq = 1'b0;
        wait_rd(ok);
        intReq = 1'b1;
        do_ack(32'h0003_0003);
        @(negedge clk);
        cfgMask = 8'h80;
        cfgLoad = 1'b1;
        checks++;
        if (busWr !== 1'b1 || busWrData !== 32'h0003_0003) begin
            failures++;
            $display("FAIL cdc_clear: wr=%b data=%h, required 1 00030003", busWr, busWrData);
        end
        @(negedge clk);
        cfgLoad = 1'b0;
        cfgMask = $urandom;
        checks++;
        if (busWrData !== 32'h0003_0003) begin
            failures++;
            $display("FAIL cdc_old_mask: data=%h, required 00030003", busWrData);
        end
        do_ack(32'h0);
        went_idle = 1'b0;
        ok = 1'b0;
        d = 32'h0;
        for (int i = 0; i < 10; i++) begin
            if (!busy) went_idle = 1'b1;
            if (busWr) begin
                ok = 1'b1;
                d = busWrData;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok || d !== 32'h0080_0000 || went_idle) begin
            failures++;
            $display("FAIL cdc_cfg: ok=%b data=%h idle_seen=%b, required 1 00800000 0", ok, d, went_idle);
        end
        if (ok) do_ack(32'h0);
        cur_mask = 8'h80;
        wait_ready(ok);
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] d;
        logic [31:0] word;
        logic [7:0] m;
        logic [7:0] exp_pend;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                m = 8'($urandom);
                cfg_write(m, ok, d);
                cur_mask = m;
                checks++;
                if (!ok || d !== {8'h00, m, 16'h0000}) begin
                    failures++;
                    $display("FAIL rnd_cfg[%0d]: ok=%b data=%h, required %h", it, ok, d, {8'h00, m, 16'h0000});
                end
            end
            word = $urandom;
            if ($urandom_range(0, 3) == 0) word[7:0] = word[7:0] & ~word[23:16];
            exp_pend = word[7:0] & word[23:16];
            intReq = 1'b0;
            wait_rd(ok);
            intReq = 1'b1;
            repeat ($urandom_range(0, 4)) @(negedge clk);
            do_ack(word);
            if (exp_pend != 8'h00) begin
                checks++;
                if (irqValid !== 1'b1 || irqEvent !== exp_pend || statusFlags !== word[15:8]) begin
                    failures++;
                    $display("FAIL rnd_event[%0d]: vld=%b ev=%h st=%h, required 1 %h %h",
                             it, irqValid, irqEvent, statusFlags, exp_pend, word[15:8]);
                end
                wait_wr(ok, d);
                checks++;
                if (!ok || d !== {8'h00, cur_mask, 8'h00, exp_pend}) begin
                    failures++;
                    $display("FAIL rnd_clear[%0d]: ok=%b data=%h, required %h",
                             it, ok, d, {8'h00, cur_mask, 8'h00, exp_pend});
                end
                repeat ($urandom_range(0, 4)) @(negedge clk);
                if (ok) do_ack(32'h0);
            end else begin
                checks++;
                if (spurious !== 1'b1 || irqValid !== 1'b0 || statusFlags !== word[15:8]) begin
                    failures++;
                    $display("FAIL rnd_spur[%0d]: spur=%b vld=%b st=%h, required 1 0 %h",
                             it, spurious, irqValid, statusFlags, word[15:8]);
                end
            end
            wait_ready(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rnd_ready[%0d]: busy=%b, required 0", it, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        intReq = 1'b0;
        wait_rd(ok);
        intReq = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busRd !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst: busRd=%b busy=%b, required 0 1", busRd, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busWr !== 1'b1 || busWrData !== 32'h0) begin
            failures++;
            $display("FAIL midrst_cfg: wr=%b data=%h, required 1 00000000", busWr, busWrData);
        end
        do_ack(32'h0);
        cur_mask = 8'h00;
        wait_ready(ok);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        cfgMask = 8'h00;
        cfgLoad = 1'b0;
        intReq = 1'b1;
        busRdData = 32'h0;
        busAck = 1'b0;
        cur_mask = 8'h00;
        @(negedge clk);
        test_reset();
        test_basic();
        test_partial();
        test_spurious();
        test_timeout();
        test_timeout_edge();
        test_cfg_during_clr();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
